// File: rtl/poly_result_log_if.sv
// Purpose: bundles the result-log stimulus (write/clear/scroll) and its
//          display/status outputs into one port.
// Signals:
//   res_valid/res_data : new result strobe and value (master -> slave)
//   clear              : synchronous history clear (master -> slave)
//   scroll             : step display to next older entry (master -> slave)
//   disp_data/disp_index, count, full, overflow, max_val : status (slave -> master)
interface poly_result_log_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    logic          res_valid;
    logic [W-1:0]  res_data;
    logic          clear;
    logic          scroll;
    logic [W-1:0]  disp_data;
    logic [IW-1:0] disp_index;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;
    logic [W-1:0]  max_val;

    modport master (
        output res_valid, res_data, clear, scroll,
        input  disp_data, disp_index, count, full, overflow, max_val
    );

    modport slave (
        input  res_valid, res_data, clear, scroll,
        output disp_data, disp_index, count, full, overflow, max_val
    );
endinterface

// File: rtl/poly_result_log.sv
// Purpose: DEPTH-entry circular history of polynomial results with a
//          scrollable display pointer, fill count, sticky overflow and
//          running unsigned maximum.
// Ports:
//   clk    : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : poly_result_log_if.slave (write/clear/scroll in, display/status out)
module poly_result_log #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    poly_result_log_if.slave  bus
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [IW-1:0] wr_ptr;
    logic [IW-1:0] disp_idx;
    logic [IW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic [W-1:0]  max_q;
    logic          do_write;

    // Clear outranks a write; reset outranks everything.
    assign do_write = resetn && !bus.clear && bus.res_valid;

    // Storage is never cleared; stale slots are masked by cnt on the read side.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= bus.res_data;
        end
    end

    // Pointer, count, display index and status flags.
    always_ff @(posedge clk) begin
        if (!resetn || bus.clear) begin
            wr_ptr   <= '0;
            cnt      <= '0;
            disp_idx <= '0;
            ovf      <= 1'b0;
            max_q    <= '0;
        end else if (bus.res_valid) begin
            wr_ptr   <= wr_ptr + IW'(1);
            disp_idx <= '0;
            if (cnt == CW'(DEPTH)) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (bus.res_data > max_q) begin
                max_q <= bus.res_data;
            end
        end else if (bus.scroll) begin
            // Walk toward older entries, wrapping after the oldest valid one.
            if (cnt <= CW'(1)) begin
                disp_idx <= '0;
            end else if (CW'(disp_idx) == cnt - CW'(1)) begin
                disp_idx <= '0;
            end else begin
                disp_idx <= disp_idx + IW'(1);
            end
        end
    end

    // Newest entry sits one slot behind wr_ptr; modulo comes from IW-bit wrap.
    assign rd_ptr = wr_ptr - IW'(1) - disp_idx;

    assign bus.disp_data  = (cnt == '0) ? '0 : mem[rd_ptr];
    assign bus.disp_index = disp_idx;
    assign bus.count      = cnt;
    assign bus.full       = (cnt == CW'(DEPTH));
    assign bus.overflow   = ovf;
    assign bus.max_val    = max_q;
endmodule

// File: tb/tb_poly_result_log.sv
module tb_poly_result_log;
    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        string name;
        int    disp_data;
        int    disp_index;
        int    count;
        int    full;
        int    overflow;
        int    max_val;
    } exp_t;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    poly_result_log_if #(.W(W), .DEPTH(DEPTH)) bus ();

    poly_result_log #(.W(W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string field, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, req);
        end
    endtask

    // Monitor: compares every queued expectation against outputs at negedge.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "disp_data",  int'(bus.disp_data),  e.disp_data);
            cmp(e.name, "disp_index", int'(bus.disp_index), e.disp_index);
            cmp(e.name, "count",      int'(bus.count),      e.count);
            cmp(e.name, "full",       int'(bus.full),       e.full);
            cmp(e.name, "overflow",   int'(bus.overflow),   e.overflow);
            cmp(e.name, "max_val",    int'(bus.max_val),    e.max_val);
        end
    end

    task automatic expect_st(input string nm, input int dd, input int di, input int cn,
                             input int fu, input int ov, input int mx);
        exp_t e;
        e.name = nm; e.disp_data = dd; e.disp_index = di; e.count = cn;
        e.full = fu; e.overflow = ov; e.max_val = mx;
        exp_q.push_back(e);
    endtask

    // One clock with the given inputs; inputs drop after the edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic c, input logic s);
        bus.res_valid = v;
        bus.res_data  = d;
        bus.clear     = c;
        bus.scroll    = s;
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.clear     = 1'b0;
        bus.scroll    = 1'b0;
    endtask

    task automatic wr(input logic [W-1:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic scr();
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        resetn = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.clear     = 1'b0;
        bus.scroll    = 1'b0;
        @(posedge clk); #1;
        do_reset();
        expect_st("reset", 0, 0, 0, 0, 0, 0);

        // Three writes, newest shown.
        wr(8'h12); expect_st("wr12", 8'h12, 0, 1, 0, 0, 8'h12);
        wr(8'h34); expect_st("wr34", 8'h34, 0, 2, 0, 0, 8'h34);
        wr(8'h56); expect_st("wr56", 8'h56, 0, 3, 0, 0, 8'h56);

        // Scroll through three entries and wrap.
        scr(); expect_st("scr1", 8'h34, 1, 3, 0, 0, 8'h56);
        scr(); expect_st("scr2", 8'h12, 2, 3, 0, 0, 8'h56);
        scr(); expect_st("scr3_wrap", 8'h56, 0, 3, 0, 0, 8'h56);

        // Five back-to-back writes: oldest (0x01) overwritten.
        do_reset();
        expect_st("reset2", 0, 0, 0, 0, 0, 0);
        wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
        expect_st("fill4", 8'h04, 0, 4, 1, 0, 8'h04);
        wr(8'h05);
        expect_st("ovf5", 8'h05, 0, 4, 1, 1, 8'h05);
        scr(); expect_st("ovf_idx1", 8'h04, 1, 4, 1, 1, 8'h05);
        scr(); expect_st("ovf_idx2", 8'h03, 2, 4, 1, 1, 8'h05);
        scr(); expect_st("ovf_idx3", 8'h02, 3, 4, 1, 1, 8'h05);
        scr(); expect_st("ovf_wrap", 8'h05, 0, 4, 1, 1, 8'h05);

        // Write and scroll together at idx2: write wins, index returns to 0.
        scr(); scr();
        expect_st("pre_ws_idx2", 8'h03, 2, 4, 1, 1, 8'h05);
        step(1'b1, 8'h9A, 1'b0, 1'b1);
        expect_st("wr_scroll", 8'h9A, 0, 4, 1, 1, 8'h9A);
        scr(); expect_st("after_ws_idx1", 8'h05, 1, 4, 1, 1, 8'h9A);

        // Clear with a simultaneous write discards the write.
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        expect_st("clear_wr", 0, 0, 0, 0, 0, 0);

        // Scroll with count 0 and count 1 keeps index at 0.
        scr(); expect_st("scr_cnt0", 0, 0, 0, 0, 0, 0);
        wr(8'h80); expect_st("wr80", 8'h80, 0, 1, 0, 0, 8'h80);
        scr(); expect_st("scr_cnt1", 8'h80, 0, 1, 0, 0, 8'h80);

        // Max only tracks upward, full 8-bit range.
        wr(8'h10); expect_st("max_hold", 8'h10, 0, 2, 0, 0, 8'h80);
        wr(8'hFF); expect_st("max_ff", 8'hFF, 0, 3, 0, 0, 8'hFF);
        scr(); expect_st("scr_after_ff", 8'h10, 1, 3, 0, 0, 8'hFF);

        // Reset mid-sequence after five writes wipes history.
        wr(8'h21); wr(8'h22);
        expect_st("pre_rst", 8'h22, 0, 4, 1, 1, 8'hFF);
        do_reset();
        expect_st("mid_reset", 0, 0, 0, 0, 0, 0);
        scr(); expect_st("post_rst_scr", 0, 0, 0, 0, 0, 0);
        wr(8'h07); expect_st("post_rst_wr", 8'h07, 0, 1, 0, 0, 8'h07);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/poly_result_log.md
POLY_RESULT_LOG -- requirements
Module: poly_result_log

Interface
REQ-001 Parameter: W, default 8, data width of result entries.
REQ-002 Parameter: DEPTH, default 4, number of history entries; SHALL be a power of two ≥2.
REQ-003 The block SHALL use reset resetn, synchronous, active-low, and clock clk.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: resetn  input  1  synchronous active-low reset.
REQ-006 Port: res_valid  input  1  one-cycle strobe marking a new polynomial result from the upstream datapath.
REQ-007 Port: res_data  input  W  result value, sampled only when res_valid=1.
REQ-008 Port: clear  input  1  synchronous active-high history clear.
REQ-009 Port: scroll  input  1  one-cycle strobe that steps the display to the next older entry.
REQ-010 Port: disp_data  output  W  entry currently selected for display.
REQ-011 Port: disp_index  output  log2(DEPTH)  age of the displayed entry; 0 = newest.
REQ-012 Port: count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-013 Port: full  output  1  high when count==DEPTH.
REQ-014 Port: overflow  output  1  sticky flag; high once any entry has been overwritten.
REQ-015 Port: max_val  output  W  largest unsigned value written since the last reset or clear.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries with write pointer wr_ptr, wrapping DEPTH-1 -> 0.
REQ-017 On res_valid=1: write res_data at wr_ptr, wr_ptr += 1 mod DEPTH, count += 1 saturating at DEPTH.
REQ-018 A write when count==DEPTH SHALL overwrite the oldest entry, keep count at DEPTH, and set overflow=1.
REQ-019 overflow SHALL remain 1 until reset or clear.
REQ-020 max_val SHALL update on each write to max(max_val, res_data), unsigned compare, with no wrap or truncation.
REQ-021 disp_data SHALL equal entry[(wr_ptr-1-disp_index) mod DEPTH], combinational from registered state, so a write is visible the cycle after res_valid.
REQ-022 When count==0, disp_data SHALL be 0 and disp_index SHALL be 0.
REQ-023 Any write SHALL set disp_index to 0 on the same clock edge.
REQ-024 On scroll=1 with no write: disp_index += 1, wrapping to 0 after count-1; if count≤1, disp_index stays 0.
REQ-025 Priority within one cycle: reset > clear > res_valid > scroll.
REQ-026 On clear: wr_ptr, count, disp_index, overflow and max_val SHALL go to 0; a simultaneous res_valid SHALL be discarded.
REQ-027 Simultaneous res_valid and scroll: the write SHALL take effect and disp_index SHALL be 0; the scroll SHALL be ignored.
REQ-028 Buffer contents need not be cleared; reads of invalid slots SHALL be masked by REQ-022 and REQ-024.
REQ-029 res_valid held high for N cycles SHALL perform N writes; no edge detection occurs in this block.

Reset
REQ-030 While resetn=0 at a clock edge, wr_ptr, count, disp_index, overflow and max_val SHALL become 0, and all inputs SHALL be ignored.
REQ-031 After reset, disp_data=0, full=0 and count=0 from the first cycle, independent of buffer contents.
REQ-032 Reset asserted mid-sequence, for example between a write and a scroll, SHALL discard all history.

Verification
REQ-033 Reset, then write 0x12,0x34,0x56 -> count=3, disp_data=0x56, disp_index=0, max_val=0x56, full=0.
REQ-034 From REQ-033 state, pulse scroll 3 times -> disp_data 0x34 (idx1), 0x12 (idx2), 0x56 (idx0 wrap).
REQ-035 Write 0x01..0x05 from reset -> count=4, full=1, overflow=1, idx3 shows 0x02, max_val=0x05.
REQ-036 Same-cycle res_valid=1 (0x9A) and scroll=1 at idx2 -> disp_index=0, disp_data=0x9A next cycle.
REQ-037 Same-cycle clear=1 and res_valid=1 (0xFF) -> count=0, max_val=0, disp_data=0, overflow=0.
REQ-038 Scroll with count=0 or 1 -> disp_index stays 0; a resetn=0 pulse after 5 writes -> all outputs 0.
